encoder_nxm_seq: RTL

//  Registered request encoder: the reverse of our 2x4 decoder. Captures N

---
 rtl/encoder_pkg.sv | 24 ++
 rtl/prio_pick.sv | 30 +++
 rtl/encoder_nxm_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the N-line request encoder.
// MAX_N bounds the one-hot helper width; N must not exceed it.
package encoder_pkg;

  localparam int N_DEF = 4;
  localparam int MAX_N = 32;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_N-1:0] onehot_f(input int idx, input int n);
    logic [MAX_N-1:0] oh;
    oh = '0;
    if (idx >= 0 && idx < n) oh = MAX_N'(1) << idx;
    return oh;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of cand_i searching upward from start_i, wrapping mod N.
// Zero latency; no flow control.
import encoder_pkg::*;

module prio_pick #(
  parameter int N = N_DEF,
  parameter int W = clog2_f(N)
) (
  input  logic [N-1:0] cand_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] k_o,
  output logic         found_o
);

  logic [W-1:0] j;

  always_comb begin
    k_o     = '0;
    found_o = 1'b0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(start_i) + i) % N);
      if (!found_o && cand_i[j]) begin
        found_o = 1'b1;
        k_o     = j;
      end
    end
  end

endmodule

// File: rtl/encoder_nxm_seq.sv
// Registered request encoder: pending set feeding a one-deep valid/ready index slot; 1 index/cycle.
// Optional ENCODER_RR_EN selects round-robin instead of lowest-index-first.
import encoder_pkg::*;

module encoder_nxm_seq #(
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [clog2_f(N)-1:0] y_idx,
  output logic [N-1:0]          pending
);

  localparam int W = clog2_f(N);

  logic [N-1:0] pending_q, pending_d;
  logic         y_valid_q, y_valid_d;
  logic [W-1:0] y_idx_q, y_idx_d;
  logic [N-1:0] cand;
  logic [W-1:0] start;
  logic [W-1:0] k;
  logic         found;
  logic         slot_free;

`ifdef ENCODER_RR_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  assign cand      = pending_q | req;
  assign slot_free = !y_valid_q || y_ready;

  prio_pick #(.N(N), .W(W)) u_pick (
    .cand_i  (cand),
    .start_i (start),
    .k_o     (k),
    .found_o (found)
  );

  always_comb begin
    pending_d = cand;
    y_valid_d = y_valid_q;
    y_idx_d   = y_idx_q;
`ifdef ENCODER_RR_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    if (slot_free) begin
      if (found) begin
        y_valid_d = 1'b1;
        y_idx_d   = k;
        pending_d = cand & ~N'(onehot_f(int'(k), N));
`ifdef ENCODER_RR_EN
        rr_ptr_d  = (int'(k) == N - 1) ? '0 : k + W'(1);
`endif
      end else begin
        y_valid_d = 1'b0;
        pending_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      y_valid_q <= 1'b0;
      y_idx_q   <= '0;
`ifdef ENCODER_RR_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      y_valid_q <= y_valid_d;
      y_idx_q   <= y_idx_d;
`ifdef ENCODER_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign y_valid = y_valid_q;
  assign y_idx   = y_idx_q;
  assign pending = pending_q;

endmodule
